// File: rtl/shift_unit_seq_pkg.sv
// Shared definitions for the sequential shift unit.
//   shift_mode_e : operation encodings carried on the 2-bit mode port
//   state_e      : control FSM states (IDLE -> SHIFT -> DONE -> IDLE)
package shift_unit_seq_pkg;

  typedef enum logic [1:0] {
    MODE_SLL = 2'b00,  // logical left, zero into LSB
    MODE_SRL = 2'b01,  // logical right, zero into MSB
    MODE_SRA = 2'b10,  // arithmetic right, MSB replicated
    MODE_ROL = 2'b11   // rotate left, MSB wraps into LSB
  } shift_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_e;

endpackage

// File: rtl/shift_unit_seq_step.sv
// shift_step: purely combinational one-bit shift of a WIDTH-bit word.
// Ports:
//   din  [WIDTH-1:0] : word to shift
//   mode [1:0]       : shift_mode_e encoding
//   dout [WIDTH-1:0] : din moved one bit position per mode
module shift_step
  import shift_unit_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] din,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] dout
);

  always_comb begin
    dout = din;
    case (shift_mode_e'(mode))
      MODE_SLL: dout = {din[WIDTH-2:0], 1'b0};
      MODE_SRL: dout = {1'b0, din[WIDTH-1:1]};
      MODE_SRA: dout = {din[WIDTH-1], din[WIDTH-1:1]};
      MODE_ROL: dout = {din[WIDTH-2:0], din[WIDTH-1]};
      default:  dout = din;
    endcase
  end

endmodule

// File: rtl/shift_unit_seq.sv
// shift_unit_seq: multi-cycle shifter, one bit position per clock.
// Ports:
//   clk, rst_n         : clock, asynchronous active-low reset
//   start              : request; only looked at while IDLE
//   mode [1:0]         : 00 SLL, 01 SRL, 10 SRA, 11 ROL
//   data_in [WIDTH-1:0]: operand, captured with the request
//   shamt [SHAMT_W-1:0]: shift count, captured with the request
//   busy               : high while the FSM is in SHIFT
//   done               : one-cycle pulse, result valid on data_out
//   data_out           : result, held until the next operation completes
// A request accepted on edge E0 finishes on edge E(shamt+1); done is high
// for the cycle that follows, so shamt=0 still costs two cycles.
module shift_unit_seq
  import shift_unit_seq_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [1:0]         mode,
  input  logic [WIDTH-1:0]   data_in,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   data_out
);

  // Largest meaningful count; wider counts only occur for non-power-of-2 WIDTH.
  localparam logic [SHAMT_W-1:0] SHAMT_MAX = SHAMT_W'(WIDTH - 1);

  state_e             state;
  shift_mode_e        mode_q;
  logic [WIDTH-1:0]   work;
  logic [WIDTH-1:0]   step_out;
  logic [SHAMT_W-1:0] cnt;
  logic [SHAMT_W-1:0] shamt_sat;

  always_comb begin
    shamt_sat = shamt;
    if (shamt > SHAMT_MAX) shamt_sat = SHAMT_MAX;
  end

  shift_step #(.WIDTH(WIDTH)) u_step (
    .din  (work),
    .mode (mode_q),
    .dout (step_out)
  );

  // Control and datapath share one block so busy/done/data_out are
  // registered alongside the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      mode_q   <= MODE_SLL;
      work     <= '0;
      cnt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      data_out <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            work   <= data_in;
            cnt    <= shamt_sat;
            mode_q <= shift_mode_e'(mode);
            busy   <= 1'b1;
            state  <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (cnt != '0) begin
            work <= step_out;
            cnt  <= cnt - 1'b1;
          end else begin
            // Count exhausted: publish without a further shift.
            data_out <= work;
            busy     <= 1'b0;
            done     <= 1'b1;
            state    <= ST_DONE;
          end
        end
        ST_DONE: state <= ST_IDLE;  // gives a held start one IDLE edge
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_unit_seq.sv
module tb_shift_unit_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic [15:0] data_in = '0;
  logic [3:0]  shamt = '0;
  logic        busy, done;
  logic [15:0] data_out;

  int checks = 0;
  int errors = 0;

  shift_unit_seq #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
    .data_in(data_in), .shamt(shamt),
    .busy(busy), .done(done), .data_out(data_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one op at a negedge, count cycles (cycle 0 = start asserted) until
  // done, and check latency, busy duration and result. poke=1 fires a stray
  // start with different operands in cycle 2 of the operation.
  task automatic run_op(input string tag, input logic [1:0] m, input logic [15:0] d,
                        input int s, input logic [15:0] exp, input bit poke);
    int lat, bcnt;
    @(negedge clk);
    start = 1'b1; mode = m; data_in = d; shamt = 4'(s);
    @(negedge clk);
    start = 1'b0;
    lat = 1; bcnt = 0;
    while (!done && lat < 40) begin
      if (busy) bcnt++;
      if (poke && lat == 2) begin
        start = 1'b1; data_in = 16'hFFFF; mode = 2'b10; shamt = 4'd1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    chk({tag, "_lat"}, 32'(lat), 32'(s + 2));
    chk({tag, "_busy"}, 32'(bcnt), 32'(s + 1));
    chk({tag, "_data"}, {16'h0, data_out}, {16'h0, exp});
    @(negedge clk);
    chk({tag, "_pulse"}, {31'h0, done}, 32'h0);
    chk({tag, "_hold"}, {16'h0, data_out}, {16'h0, exp});
  endtask

  initial begin
    int n;
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_done", {31'h0, done}, 32'h0);
    chk("rst_data", {16'h0, data_out}, 32'h0);
    rst_n = 1'b1;

    // SLL by one, including the legacy shift-left-by-one cases
    run_op("sll5",  2'b00, 16'h0005, 1, 16'h000A, 1'b0);
    run_op("sll13", 2'b00, 16'h0013, 1, 16'h0026, 1'b0);
    run_op("sll7",  2'b00, 16'h0007, 1, 16'h000E, 1'b0);

    // Right shifts
    run_op("sra4", 2'b10, 16'h8000, 4, 16'hF800, 1'b0);
    run_op("srl4", 2'b01, 16'h8000, 4, 16'h0800, 1'b0);

    // Rotates, including the maximum count
    run_op("rol1",  2'b11, 16'h8001, 1,  16'h0003, 1'b0);
    run_op("rol15", 2'b11, 16'h1234, 15, 16'h091A, 1'b0);
    run_op("sll15", 2'b00, 16'hFFFF, 15, 16'h8000, 1'b0);

    // Zero count passes the operand through in every mode
    run_op("z_sll", 2'b00, 16'hBEEF, 0, 16'hBEEF, 1'b0);
    run_op("z_srl", 2'b01, 16'hBEEF, 0, 16'hBEEF, 1'b0);
    run_op("z_sra", 2'b10, 16'hBEEF, 0, 16'hBEEF, 1'b0);
    run_op("z_rol", 2'b11, 16'hBEEF, 0, 16'hBEEF, 1'b0);

    // Stray start during SHIFT is ignored
    run_op("stray", 2'b00, 16'h0005, 4, 16'h0050, 1'b1);

    // Start held high across done: op1 SLL 0x0003<<2, op2 SRL 0x00F0>>1
    @(negedge clk);
    start = 1'b1; mode = 2'b00; data_in = 16'h0003; shamt = 4'd2;
    @(negedge clk);                       // cycle 1, op1 accepted
    mode = 2'b01; data_in = 16'h00F0; shamt = 4'd1;
    repeat (3) @(negedge clk);            // cycle 4
    chk("held_done1", {31'h0, done}, 32'h1);
    chk("held_data1", {16'h0, data_out}, 32'h000C);
    @(negedge clk);                       // cycle 5, IDLE
    chk("held_idle_busy", {31'h0, busy}, 32'h0);
    chk("held_idle_done", {31'h0, done}, 32'h0);
    @(negedge clk);                       // cycle 6, op2 running
    start = 1'b0;
    chk("held_busy2", {31'h0, busy}, 32'h1);
    chk("held_keep", {16'h0, data_out}, 32'h000C);
    repeat (2) @(negedge clk);            // cycle 8
    chk("held_done2", {31'h0, done}, 32'h1);
    chk("held_data2", {16'h0, data_out}, 32'h0078);
    @(negedge clk);

    // Reset mid-operation (shamt=10), asynchronous clear
    @(negedge clk);
    start = 1'b1; mode = 2'b00; data_in = 16'h0001; shamt = 4'd10;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);            // cycle 3
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", {31'h0, busy}, 32'h0);
    chk("arst_done", {31'h0, done}, 32'h0);
    chk("arst_data", {16'h0, data_out}, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    repeat (15) begin
      @(negedge clk);
      if (done) n++;
    end
    chk("arst_no_done", 32'(n), 32'h0);
    chk("arst_idle", {31'h0, busy}, 32'h0);
    run_op("post_rst", 2'b10, 16'hC000, 2, 16'hF000, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Safety net against a hang
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/shift_unit_seq.md
SHIFT_UNIT_SEQ -- requirements
Module: shift_unit_seq

Interface
REQ-001 Parameter WIDTH, default 16: operand and result width in bits, minimum 2.
REQ-002 Parameter SHAMT_W, default $clog2(WIDTH): width of the shift-amount port.
REQ-003 Port clk  input  1: single clock; all state updates on the rising edge.
REQ-004 Port rst_n  input  1: reset, asynchronous, active-low.
REQ-005 Port start  input  1: request a new shift; sampled only in IDLE.
REQ-006 Port mode  input  2: operation select. 00 SLL, 01 SRL, 10 SRA, 11 ROL (rotate left).
REQ-007 Port data_in  input  WIDTH: operand, captured on an accepted start.
REQ-008 Port shamt  input  SHAMT_W: shift count, captured on an accepted start, range 0..WIDTH-1.
REQ-009 Port busy  output  1: high while in SHIFT.
REQ-010 Port done  output  1: one-cycle pulse when the result is valid.
REQ-011 Port data_out  output  WIDTH: result, held stable from done until the next accepted start.

Function
REQ-012 FSM states: IDLE, SHIFT, DONE. No other states are reachable.
REQ-013 IDLE + start=1: capture data_in into the working register, shamt into the counter and mode, then go to SHIFT.
REQ-014 SHIFT with counter != 0: shift the working register one bit per the captured mode and decrement the counter.
REQ-015 SHIFT with counter == 0: go to DONE without shifting and copy the working register to data_out.
REQ-016 DONE: assert done for exactly that cycle, then return to IDLE unconditionally.
REQ-017 Latency: done is high in the cycle after the edge that is shamt+1 edges after the accepting edge. shamt=0 gives 2 cycles from start to done.
REQ-018 SLL: insert 0 at the LSB. SRL: insert 0 at the MSB. SRA: replicate the MSB. ROL: the MSB wraps into the LSB.
REQ-019 start while in SHIFT or DONE is ignored. Operands and mode do not change mid-operation, and no request is queued.
REQ-020 start held high continuously: a new operation is accepted on the first IDLE edge after DONE, with no back-to-back in the same cycle as done.
REQ-021 shamt values >= WIDTH (possible only when WIDTH is not a power of 2) saturate to WIDTH-1.
REQ-022 data_out does not change except on the SHIFT-to-DONE transition.

Reset
REQ-023 rst_n low forces IDLE immediately, without waiting for a clock edge.
REQ-024 rst_n low clears busy=0, done=0, data_out=0, and clears the working register and counter to 0.
REQ-025 Reset asserted mid-operation aborts the operation. No done is produced for it.
REQ-026 The first start is accepted on the first rising edge after rst_n deasserts.

Structure
REQ-027 A shared package holds the mode encodings (SLL, SRL, SRA, ROL) and the FSM state enum.
REQ-028 One combinational sub-module, shift_step, performs a one-bit shift of WIDTH bits per mode. It is instantiated once in the datapath.
REQ-029 The parametrised design at WIDTH=16, SLL, shamt=1 shall reproduce the legacy fixed shift-left-by-one result.

Verification
REQ-030 SLL, data_in=0x0005, shamt=1 -> data_out=0x000A, done 3 cycles after start. Then data_in=0x0013 -> 0x0026. Then data_in=0x0007 -> 0x000E.
REQ-031 SRA, data_in=0x8000, shamt=4 -> data_out=0xF800. SRL with the same inputs -> 0x0800. busy is high for exactly 5 cycles.
REQ-032 ROL, data_in=0x8001, shamt=1 -> 0x0003. ROL, data_in=0x1234, shamt=15 -> 0x091A.
REQ-033 shamt=0, data_in=0xBEEF, any mode -> data_out=0xBEEF, done 2 cycles after start.
REQ-034 start pulsed again during SHIFT with data_in=0xFFFF -> ignored, and the original result is unaffected. start held high across done -> a second operation starts in the cycle after done.
REQ-035 rst_n dropped at cycle 3 of a shamt=10 operation -> outputs are 0 immediately, no done pulse, and a fresh start after release completes correctly.
